// File: rtl/serial_pkg.sv
// Shared definitions for the serial sender/receiver pair: FSM states,
// parity modes and the parity helper both ends must agree on.
package serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_PARITY = 3'd2,
    S_DATA   = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Callers zero-extend narrower words; extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [15:0] data, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data; only built when
// SENDER_TX_FIFO_EN is defined. A push into a full FIFO is taken when a pop occurs together with it.
`ifdef SENDER_TX_FIFO_EN
module sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end
endmodule
`endif

// File: rtl/serial_sender_p.sv
// Parametrised serial frame transmitter: start, optional parity, LSB-first data, stop bits.
// Define SENDER_TX_FIFO_EN to buffer words in a sync_fifo and chain frames back-to-back.
module serial_sender_p
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 7,
  parameter int unsigned PARITY_MODE  = PARITY_EVEN,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter logic        START_SIG    = 1'b1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              s_out,
  output logic              busy,
  output logic              sent
);
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CLKS_PER_BIT - 1);

  if (DATA_W < 1 || DATA_W > 16 || STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 1 ||
      PARITY_MODE > PARITY_ODD || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_params
    $error("serial_sender_p: illegal parameter combination");
  end

  state_t            state;
  logic [BIT_W-1:0]  bit_idx;
  logic [TICK_W-1:0] tick;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              frame_done;
  logic              tick_last;
  logic              eof_now;
  logic              have_word;
  logic [DATA_W-1:0] word;
  logic              load;
  logic              line;

  assign tick_last = (tick == LAST_TICK);
  assign eof_now   = (state == S_STOP) && tick_last && (bit_idx == LAST_STOP);

`ifdef SENDER_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  // The FIFO head feeds the next frame, either from idle or straight off the last stop tick.
  assign have_word = !fifo_empty;
  assign load      = have_word && ((state == S_IDLE) || eof_now);
  assign in_ready  = !fifo_full || load;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstN  (rstN),
    .push  (in_valid && in_ready),
    .wdata (in_data),
    .pop   (load),
    .rdata (word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  assign have_word = in_valid;
  assign word      = in_data;
  assign in_ready  = (state == S_IDLE);
  assign load      = in_ready && have_word;
`endif

  always_comb begin
    line = ~START_SIG;
    case (state)
      S_START:  line = START_SIG;
      S_PARITY: line = par_bit;
      S_DATA:   line = shreg[0];
      default:  line = ~START_SIG;
    endcase
  end

  // Outputs are registered from the pre-edge state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= S_IDLE;
      bit_idx    <= '0;
      tick       <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      frame_done <= 1'b0;
      s_out      <= ~START_SIG;
      busy       <= 1'b0;
      sent       <= 1'b0;
    end else begin
      s_out      <= line;
      busy       <= state inside {S_START, S_PARITY, S_DATA, S_STOP};
      sent       <= frame_done;
      frame_done <= eof_now;
      tick       <= tick_last ? '0 : tick + 1'b1;

      case (state)
        S_IDLE: begin
          tick    <= '0;
          bit_idx <= '0;
        end
        S_START:
          if (tick_last) state <= (PARITY_MODE == PARITY_NONE) ? S_DATA : S_PARITY;
        S_PARITY:
          if (tick_last) state <= S_DATA;
        S_DATA:
          if (tick_last) begin
            shreg <= shreg >> 1;
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              state   <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        S_STOP:
          if (tick_last) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              state   <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        default: begin
          state   <= S_IDLE;
          tick    <= '0;
          bit_idx <= '0;
        end
      endcase

      if (load) begin
        state   <= S_START;
        shreg   <= word;
        par_bit <= parity_bit(16'(word), PARITY_MODE);
      end
    end
  end

endmodule
